// File: rtl/demux_14_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready input and per-channel valid/ack outputs.
// Optional build macro DEMUX_OVERWRITE_EN: drop backpressure, overwrite full channels and flag them in demux_ovf.
module demux_14_reg #(
    parameter int WIDTH = 8
) (
    input  logic             demux_clk,
    input  logic             demux_rst_n,
    input  logic             demux_en,
    input  logic             demux_auto,
    input  logic             demux_s1,
    input  logic             demux_s0,
    input  logic [WIDTH-1:0] demux_in,
    input  logic             demux_in_valid,
    output logic             demux_in_ready,
    output logic [WIDTH-1:0] demux_out0,
    output logic [WIDTH-1:0] demux_out1,
    output logic [WIDTH-1:0] demux_out2,
    output logic [WIDTH-1:0] demux_out3,
    output logic [3:0]       demux_vld,
    input  logic [3:0]       demux_ack,
    output logic [3:0]       demux_ovf,
    output logic [1:0]       demux_ptr
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       vld_q;
    logic [3:0]       vld_d;
    logic [3:0]       ovf_q;
    logic [3:0]       ovf_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [1:0]       tgt_s;
    logic             room_s;
    logic             accept_s;

    // Target channel: round-robin pointer or select lines
    always_comb begin
        if (demux_auto) begin
            tgt_s = ptr_q;
        end else begin
            tgt_s = {demux_s1, demux_s0};
        end
    end

`ifdef DEMUX_OVERWRITE_EN
    assign room_s = 1'b1;
`else
    // A full target can still accept when its consumer drains it in the same cycle.
    assign room_s = ~vld_q[tgt_s] | demux_ack[tgt_s];
`endif

    assign demux_in_ready = demux_rst_n & demux_en & room_s;
    assign accept_s       = demux_in_valid & demux_in_ready;

    // Next-state: load target on accept, clear acked valids, advance pointer in auto mode
    always_comb begin
        vld_d = vld_q & ~demux_ack;
`ifdef DEMUX_OVERWRITE_EN
        ovf_d = ovf_q & ~demux_ack;
`else
        ovf_d = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            if (accept_s && (tgt_s == 2'(i))) begin
                data_d[i] = demux_in;
                vld_d[i]  = 1'b1;
`ifdef DEMUX_OVERWRITE_EN
                if (vld_q[i] && !demux_ack[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = ovf_d[i];
                end
`endif
            end else begin
                data_d[i] = data_q[i];
            end
        end
        if (accept_s && demux_auto) begin
            ptr_d = ptr_q + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge demux_clk or negedge demux_rst_n) begin
        if (!demux_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= 4'b0000;
            ovf_q <= 4'b0000;
            ptr_q <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            ptr_q <= ptr_d;
        end
    end

    assign demux_out0 = data_q[0];
    assign demux_out1 = data_q[1];
    assign demux_out2 = data_q[2];
    assign demux_out3 = data_q[3];
    assign demux_vld  = vld_q;
    assign demux_ovf  = ovf_q;
    assign demux_ptr  = ptr_q;

endmodule

// File: tb/tb_demux_14_reg.sv
// Scoreboard bench for demux_14_reg: stimulus queues expected (channel, word) pairs, a monitor checks each accept.
module tb_demux_14_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       auto_m;
    logic       s1;
    logic       s0;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic [3:0] vld;
    logic [3:0] ack;
    logic [3:0] ovf;
    logic [1:0] ptr;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mon_e;
    logic [1:0] mon_tgt;

    always #5 clk = ~clk;

    demux_14_reg #(.WIDTH(8)) dut (
        .demux_clk      (clk),
        .demux_rst_n    (rst_n),
        .demux_en       (en),
        .demux_auto     (auto_m),
        .demux_s1       (s1),
        .demux_s0       (s0),
        .demux_in       (din),
        .demux_in_valid (in_valid),
        .demux_in_ready (in_ready),
        .demux_out0     (out0),
        .demux_out1     (out1),
        .demux_out2     (out2),
        .demux_out3     (out3),
        .demux_vld      (vld),
        .demux_ack      (ack),
        .demux_ovf      (ovf),
        .demux_ptr      (ptr)
    );

    function automatic logic [7:0] outsel(input logic [1:0] c);
        case (c)
            2'd0:    outsel = out0;
            2'd1:    outsel = out1;
            2'd2:    outsel = out2;
            default: outsel = out3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic a, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] k, input logic e);
        in_valid = v;
        auto_m   = a;
        {s1, s0} = s;
        din      = d;
        ack      = k;
        en       = e;
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        e.ch = c;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every handshake must match the oldest expected word, one cycle later
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            mon_tgt = auto_m ? ptr : {s1, s0};
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got word %0h on ch %0d expected no accept", din, mon_tgt);
            end else begin
                mon_e = exp_q.pop_front();
                chk("accept_ch", 32'(mon_tgt), 32'(mon_e.ch));
                chk("accept_data", 32'(outsel(mon_e.ch)), 32'(mon_e.d));
                chk("accept_vld", 32'(vld[mon_e.ch]), 32'd1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        #3;
        chk("reset_vld", 32'(vld), 32'd0);
        chk("reset_ptr", 32'(ptr), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_out0", 32'(out0), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Select mode fill of all four channels
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'(i), 8'hA0 + 8'(i), 4'b0000, 1'b1);
            push(2'(i), 8'hA0 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        chk("select_vld_full", 32'(vld), 32'hF);
        chk("select_out3", 32'(out3), 32'hA3);
`ifndef DEMUX_OVERWRITE_EN
        drive(1'b1, 1'b0, 2'd2, 8'hB2, 4'b0000, 1'b1);
        #1;
        chk("full_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("full_out2_held", 32'(out2), 32'hA2);
        in_valid = 1'b0;
`endif

        // Same-cycle accept and ack on channel 1
        drive(1'b1, 1'b0, 2'd1, 8'h11, 4'b0010, 1'b1);
        push(2'd1, 8'h11);
        step();
        drive(1'b1, 1'b0, 2'd1, 8'h22, 4'b0010, 1'b1);
        push(2'd1, 8'h22);
        step();
        chk("same_cycle_vld1", 32'(vld[1]), 32'd1);
        chk("same_cycle_out1", 32'(out1), 32'h22);
        chk("same_cycle_ovf", 32'(ovf), 32'd0);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        step();
        chk("ack_all_vld", 32'(vld), 32'd0);

        // Round-robin stream with everything acked each cycle
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 2'd0, 8'(k), 4'b1111, 1'b1);
            push(2'(k % 4), 8'(k));
            step();
        end
        drive(1'b0, 1'b1, 2'd0, 8'h00, 4'b0000, 1'b1);
        chk("rr_ptr", 32'(ptr), 32'd2);
        chk("rr_vld", 32'(vld), 32'b0010);
        drive(1'b1, 1'b0, 2'd2, 8'h77, 4'b0000, 1'b1);
        push(2'd2, 8'h77);
        step();
        chk("select_ptr_hold", 32'(ptr), 32'd2);
        drive(1'b1, 1'b1, 2'd0, 8'h06, 4'b0000, 1'b1);
`ifndef DEMUX_OVERWRITE_EN
        #1;
        chk("rr_stall_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rr_stall_ptr", 32'(ptr), 32'd2);
        chk("rr_stall_out2", 32'(out2), 32'h77);
`endif
        ack = 4'b0100;
        push(2'd2, 8'h06);
        step();
        chk("rr_resume_ptr", 32'(ptr), 32'd3);
        chk("rr_resume_vld", 32'(vld), 32'b0110);

        // Enable gating: no accepts, ack still clears channel 0
        drive(1'b1, 1'b0, 2'd0, 8'h99, 4'b0000, 1'b1);
        push(2'd0, 8'h99);
        step();
        chk("gate_pre_vld", 32'(vld), 32'b0111);
        drive(1'b1, 1'b1, 2'd0, 8'hAA, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ack = (c == 2) ? 4'b0001 : 4'b0000;
            #1;
            chk("gate_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("gate_ptr", 32'(ptr), 32'd3);
        chk("gate_vld", 32'(vld), 32'b0110);

        // Asynchronous reset mid-cycle with vld = 0101
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        step();
        drive(1'b1, 1'b0, 2'd0, 8'hC0, 4'b0000, 1'b1);
        push(2'd0, 8'hC0);
        step();
        drive(1'b1, 1'b0, 2'd2, 8'hC2, 4'b0000, 1'b1);
        push(2'd2, 8'hC2);
        step();
        drive(1'b1, 1'b0, 2'd1, 8'hDD, 4'b0000, 1'b1);
        chk("pre_reset_vld", 32'(vld), 32'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_vld", 32'(vld), 32'd0);
        chk("async_reset_ptr", 32'(ptr), 32'd0);
        chk("async_reset_out0", 32'(out0), 32'd0);
        chk("async_reset_out2", 32'(out2), 32'd0);
        chk("async_reset_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Second write to a full channel 3 without ack
        drive(1'b1, 1'b0, 2'd3, 8'h55, 4'b0000, 1'b1);
        push(2'd3, 8'h55);
        step();
        drive(1'b1, 1'b0, 2'd3, 8'h66, 4'b0000, 1'b1);
`ifdef DEMUX_OVERWRITE_EN
        push(2'd3, 8'h66);
        step();
        chk("ovw_out3", 32'(out3), 32'h66);
        chk("ovw_ovf", 32'(ovf), 32'b1000);
        drive(1'b0, 1'b0, 2'd3, 8'h00, 4'b1000, 1'b1);
        step();
        chk("ovw_ack_vld3", 32'(vld[3]), 32'd0);
        chk("ovw_ack_ovf", 32'(ovf), 32'd0);
`else
        #1;
        chk("ovw_stall_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("ovw_stall_out3", 32'(out3), 32'h55);
        chk("ovw_stall_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
`endif
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
